// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared helpers and reset constants for the parametrised
// serial pattern detector.
//   PROG_W(p) : width needed to hold a prefix length 0..p
//   len_rst() : reset value of the latched pattern length (full width)
//   OVL_RST   : reset value of the latched overlap mode (overlap enabled)
package seq_det_pkg;

   localparam logic OVL_RST = 1'b1;

   function automatic int PROG_W(input int p);
      return $clog2(p + 1);
   endfunction

   function automatic int len_rst(input int pat_w);
      return pat_w;
   endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// seq_prefix_match: combinational longest-prefix search.
// Finds the largest k <= min(fill, len) such that the newest k history bits
// equal the first k bits of the pattern (pat[len-1 -: k]).
// Ports:
//   hist : history after the current bit is shifted in, newest bit at bit 0
//   fill : number of history bits belonging to the current epoch
//   pat  : latched pattern, pat[len-1] is the first expected bit
//   len  : latched pattern length (1..PAT_W)
//   k    : resulting prefix-match length (0 when nothing matches)
module seq_prefix_match
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8
)
(
   input  logic [PAT_W-1:0]         hist,
   input  logic [PROG_W(PAT_W)-1:0] fill,
   input  logic [PAT_W-1:0]         pat,
   input  logic [PROG_W(PAT_W)-1:0] len,
   output logic [PROG_W(PAT_W)-1:0] k
);

   localparam int PW = PROG_W(PAT_W);

   logic [PAT_W:1] hit_s;

   // Compares the n newest history bits against the n-bit pattern prefix.
   // The prefix pat[l-1:l-n] is right-aligned by shifting by (l-n) so its
   // last bit lines up with the newest history bit.
   function automatic logic prefix_hit(input logic [PAT_W-1:0] h,
                                       input logic [PAT_W-1:0] p,
                                       input int n,
                                       input int l);
      logic [PAT_W-1:0] mask;
      logic [PAT_W-1:0] aligned;
      mask    = (n >= PAT_W) ? {PAT_W{1'b1}} : ~({PAT_W{1'b1}} << n);
      aligned = p >> (l - n);
      return (((aligned ^ h) & mask) == {PAT_W{1'b0}});
   endfunction

   // Candidate lengths that fit the epoch and the pattern and actually match
   always_comb begin
      hit_s = {PAT_W{1'b0}};
      for (int c = 1; c <= PAT_W; c++) begin
         hit_s[c] = (c <= int'(fill)) && (c <= int'(len)) &&
                    prefix_hit(hist, pat, c, int'(len));
      end
   end

   // Priority pick: the longest matching candidate wins
   always_comb begin
      k = {PW{1'b0}};
      for (int c = 1; c <= PAT_W; c++) begin
         k = hit_s[c] ? PW'(c) : k;
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: run-time configurable serial pattern detector.
// Ports:
//   clock, reset_n           : rising-edge clock, async active-low reset
//   in_bit, in_valid         : serial data and its qualifier
//   cfg_load                 : latch cfg_pattern/cfg_len/cfg_overlap, restart
//   cfg_pattern, cfg_len     : pattern (MSB of the used field first) and length
//   cfg_overlap              : 1 = overlapping matches, 0 = restart after match
//   clr_count                : synchronous clear of match_count
//   match                    : registered one-cycle match pulse
//   progress                 : registered longest matched prefix length
//   match_count              : saturating match counter
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
)
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_bit,
   input  logic                     in_valid,
   input  logic                     cfg_load,
   input  logic [PAT_W-1:0]         cfg_pattern,
   input  logic [PROG_W(PAT_W)-1:0] cfg_len,
   input  logic                     cfg_overlap,
   input  logic                     clr_count,
   output logic                     match,
   output logic [PROG_W(PAT_W)-1:0] progress,
   output logic [CNT_W-1:0]         match_count
);

   localparam int             PW      = PROG_W(PAT_W);
   localparam logic [PW-1:0]  LEN_MAX = PW'(len_rst(PAT_W));
   localparam logic [PW-1:0]  PW_ONE  = PW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [PAT_W-1:0] pat_r;
   logic [PW-1:0]    len_r;
   logic             ovl_r;
   logic [PAT_W-1:0] hist_r;
   logic [PW-1:0]    fill_r;

   logic [PAT_W-1:0] hist_nxt_s;
   logic [PW-1:0]    fill_nxt_s;
   logic [PW-1:0]    cfg_len_s;
   logic [PW-1:0]    k_s;
   logic             hit_s;

   // Look-ahead state after the current bit, sanitised length, match decision
   always_comb begin
      hist_nxt_s = {hist_r[PAT_W-2:0], in_bit};
      fill_nxt_s = (fill_r == LEN_MAX) ? fill_r : (fill_r + PW_ONE);
      cfg_len_s  = ((cfg_len == {PW{1'b0}}) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
      // cfg_load drops any bit presented in the same cycle
      hit_s      = in_valid & ~cfg_load & (k_s == len_r);
   end

   seq_prefix_match #(
      .PAT_W (PAT_W)
   ) u_prefix (
      .hist (hist_nxt_s),
      .fill (fill_nxt_s),
      .pat  (pat_r),
      .len  (len_r),
      .k    (k_s)
   );

   // Configuration, history, epoch fill and detector outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pat_r    <= {PAT_W{1'b0}};
         len_r    <= LEN_MAX;
         ovl_r    <= OVL_RST;
         hist_r   <= {PAT_W{1'b0}};
         fill_r   <= {PW{1'b0}};
         progress <= {PW{1'b0}};
         match    <= 1'b0;
      end else if (cfg_load) begin
         pat_r    <= cfg_pattern;
         len_r    <= cfg_len_s;
         ovl_r    <= cfg_overlap;
         hist_r   <= {PAT_W{1'b0}};
         fill_r   <= {PW{1'b0}};
         progress <= {PW{1'b0}};
         match    <= 1'b0;
      end else if (in_valid) begin
         hist_r   <= hist_nxt_s;
         progress <= k_s;
         match    <= hit_s;
         // Non-overlap mode starts a fresh epoch right after a match
         fill_r   <= (hit_s & ~ovl_r) ? {PW{1'b0}} : fill_nxt_s;
      end else begin
         match    <= 1'b0;
      end
   end

   // Saturating match counter; a clear coinciding with a match leaves 1
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         match_count <= {CNT_W{1'b0}};
      end else if (clr_count) begin
         match_count <= hit_s ? CNT_ONE : {CNT_W{1'b0}};
      end else if (hit_s && (match_count != CNT_MAX)) begin
         match_count <= match_count + CNT_ONE;
      end else begin
         match_count <= match_count;
      end
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed bench for seq_detect_param. Two instances
// (CNT_W = 8 and CNT_W = 2) share stimulus; a bit-queue reference model
// predicts every output each cycle, and literal expectations pin the model.
module tb_seq_detect_param;

   localparam int PAT_W = 8;
   localparam int PW    = $clog2(PAT_W + 1);

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic          in_bit = 1'b0;
   logic          in_valid = 1'b0;
   logic          cfg_load = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic [PW-1:0] cfg_len = '0;
   logic          cfg_overlap = 1'b0;
   logic          clr_count = 1'b0;

   logic          match_a, match_b;
   logic [PW-1:0] progress_a, progress_b;
   logic [7:0]    count_a;
   logic [1:0]    count_b;

   int pass_cnt = 0;
   int total_cnt = 0;

   // reference model state
   bit          q[$];
   logic [PAT_W-1:0] m_pat;
   int          m_len;
   bit          m_ovl;
   int          m_prog;
   bit          m_match;
   int          m_cnt_a;
   int          m_cnt_b;

   seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
      .clock(clock), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .clr_count(clr_count),
      .match(match_a), .progress(progress_a), .match_count(count_a));

   seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
      .clock(clock), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .clr_count(clr_count),
      .match(match_b), .progress(progress_b), .match_count(count_b));

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_pat = '0; m_len = PAT_W; m_ovl = 1'b1;
      m_prog = 0; m_match = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
   endtask

   // Sequence-level model: keep the epoch's bits, find the longest tail that
   // equals the head of the pattern.
   task automatic model_step();
      bit hit;
      int k, lim;
      bit ok;
      hit = 1'b0;
      if (cfg_load) begin
         m_pat = cfg_pattern;
         m_len = (cfg_len == 0 || int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
         m_ovl = cfg_overlap;
         q.delete();
         m_prog = 0;
         m_match = 1'b0;
      end else if (in_valid) begin
         q.push_back(in_bit);
         if (q.size() > PAT_W) void'(q.pop_front());
         k = 0;
         lim = (q.size() < m_len) ? q.size() : m_len;
         for (int c = 1; c <= lim; c++) begin
            ok = 1'b1;
            for (int i = 0; i < c; i++)
               if (q[q.size() - c + i] != m_pat[m_len - 1 - i]) ok = 1'b0;
            if (ok) k = c;
         end
         m_prog = k;
         hit = (k == m_len);
         m_match = hit;
         if (hit && !m_ovl) q.delete();
      end else begin
         m_match = 1'b0;
      end
      if (clr_count) begin
         m_cnt_a = hit ? 1 : 0;
         m_cnt_b = hit ? 1 : 0;
      end else if (hit) begin
         if (m_cnt_a < 255) m_cnt_a++;
         if (m_cnt_b < 3) m_cnt_b++;
      end
   endtask

   task automatic compare_all();
      chk("match_a", match_a, m_match);
      chk("progress_a", progress_a, m_prog);
      chk("count_a", count_a, m_cnt_a);
      chk("match_b", match_b, m_match);
      chk("progress_b", progress_b, m_prog);
      chk("count_b", count_b, m_cnt_b);
   endtask

   // one clock: model sees the inputs the DUT samples, outputs checked at negedge
   task automatic tick();
      model_step();
      @(posedge clock);
      @(negedge clock);
      compare_all();
   endtask

   task automatic send(input bit b);
      in_valid = 1'b1; in_bit = b; cfg_load = 1'b0; clr_count = 1'b0;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
      tick();
   endtask

   task automatic load(input logic [PAT_W-1:0] p, input logic [PW-1:0] l, input bit o);
      cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      clr_count = 1'b1; in_valid = 1'b0;
      tick();
      cfg_load = 1'b0; clr_count = 1'b0;
   endtask

   initial begin
      logic [6:0] s7;
      logic [7:0] s8;
      int exp_prog_ovl[7] = '{1, 2, 3, 4, 2, 3, 4};
      int exp_prog_non[7] = '{1, 2, 3, 4, 0, 0, 1};
      int exp_cnt_sat[6]  = '{0, 1, 2, 3, 3, 3};
      s7 = 7'b1001001;

      // reset state
      #2 reset_n = 1'b0;
      model_reset();
      #1 compare_all();
      chk("rst_progress", progress_a, 0);
      @(negedge clock);
      reset_n = 1'b1;

      // overlap on, 1001 over 1001001
      load(8'b0000_1001, 4'd4, 1'b1);
      for (int i = 0; i < 7; i++) begin
         send(s7[6 - i]);
         chk("ovl_prog", progress_a, exp_prog_ovl[i]);
         chk("ovl_match", match_a, (i == 3 || i == 6) ? 1 : 0);
      end
      chk("ovl_count", count_a, 2);

      // overlap off, same stream
      load(8'b0000_1001, 4'd4, 1'b0);
      for (int i = 0; i < 7; i++) begin
         send(s7[6 - i]);
         chk("non_prog", progress_a, exp_prog_non[i]);
         chk("non_match", match_a, (i == 3) ? 1 : 0);
      end
      chk("non_count", count_a, 1);

      // valid gaps: two idle cycles after every bit
      load(8'b0000_1001, 4'd4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(s7[6 - i]);
         chk("gap_match", match_a, (i == 3) ? 1 : 0);
         for (int j = 0; j < 2; j++) begin
            idle();
            chk("gap_hold", progress_a, i + 1);
            chk("gap_nomatch", match_a, 0);
         end
      end

      // counter saturation on the CNT_W = 2 instance, pattern 11 overlapping
      load(8'b0000_0011, 4'd2, 1'b1);
      for (int i = 0; i < 6; i++) begin
         send(1'b1);
         chk("sat_count_b", count_b, exp_cnt_sat[i]);
      end
      chk("sat_count_a", count_a, 5);
      in_valid = 1'b1; in_bit = 1'b1; clr_count = 1'b1;
      tick();
      in_valid = 1'b0; clr_count = 1'b0;
      chk("clr_hit_b", count_b, 1);
      chk("clr_hit_a", count_a, 1);

      // cfg_len = 0 latches full length; concurrent bit is dropped
      cfg_load = 1'b1; cfg_pattern = 8'hA5; cfg_len = 4'd0; cfg_overlap = 1'b1;
      in_valid = 1'b1; in_bit = 1'b1; clr_count = 1'b0;
      tick();
      cfg_load = 1'b0; in_valid = 1'b0;
      chk("len0_prog", progress_a, 0);
      s7 = 7'b0100101;
      for (int i = 0; i < 7; i++) send(s7[6 - i]);
      chk("len0_prog7", progress_a, 3);
      chk("len0_nomatch", match_a, 0);
      s8 = 8'b10100101;
      for (int i = 0; i < 8; i++) send(s8[7 - i]);
      chk("len0_match", match_a, 1);
      chk("len0_full", progress_a, 8);

      // back-to-back loads: out-of-range length first, last load wins
      load(8'hFF, 4'd12, 1'b0);
      load(8'b0000_1001, 4'd4, 1'b1);
      s7 = 7'b1001001;
      for (int i = 0; i < 4; i++) send(s7[6 - i]);
      chk("b2b_match", match_a, 1);

      // async reset mid-stream, outputs clear before the next edge
      send(1'b0);
      send(1'b0);
      #1 reset_n = 1'b0;
      model_reset();
      #1 compare_all();
      chk("arst_prog", progress_a, 0);
      chk("arst_count", count_a, 0);
      @(negedge clock);
      reset_n = 1'b1;
      // default config: pattern 0, length PAT_W; first bit is bit 1 of epoch
      send(1'b0);
      chk("post_rst_prog", progress_a, 1);
      send(1'b0);
      send(1'b1);
      chk("post_rst_zero", progress_a, 0);
      idle();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector: the successor to the fixed 4‑state "1001" Moore detector. Pattern, pattern length and overlap mode are run-time configurable. Input bits are qualified by a valid strobe. The block reports a match pulse, the current prefix-match progress (the generalised FSM state), and a saturating match counter. It sits on a serial input line and drives flag and status logic downstream.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits, legal range 2..16.
- `CNT_W`, default 8: width of the match counter.
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_bit`  in  1: serial data bit.
- `in_valid`  in  1: `in_bit` is sampled on this edge.
- `cfg_load`  in  1: latch `cfg_pattern`, `cfg_len` and `cfg_overlap`, and clear history.
- `cfg_pattern`  in  PAT_W: pattern; `cfg_pattern[len-1]` is the first bit expected.
- `cfg_len`  in  $clog2(PAT_W+1): pattern length.
- `cfg_overlap`  in  1: 1 = overlapping matches allowed; 0 = restart after each match.
- `clr_count`  in  1: synchronous clear of `match_count`.
- `match`  out  1: one-cycle pulse, registered.
- `progress`  out  $clog2(PAT_W+1): length of the longest matched prefix, registered.
- `match_count`  out  CNT_W: saturating count of matches.

## Operation
- Latched configuration registers:
  - `pat`, `len` and `ovl`.
  - Reset values: `pat` = 0, `len` = PAT_W, `ovl` = 1.
  - `cfg_len` values of 0 or greater than PAT_W are latched as PAT_W.
- History register `hist[PAT_W-1:0]`:
  - The newest bit is at bit 0.
  - On a valid bit: `hist <= {hist[PAT_W-2:0], in_bit}`.
- Fill counter `fill`:
  - Holds the number of bits accepted since the last epoch start, saturating at PAT_W.
  - Only the newest `fill` bits take part in matching.
- Next progress `k`:
  - `k` is the largest value with `k ≤ min(fill', len)` and `hist'[k-1:0] == pat[len-1 -: k]`.
  - Primed values denote the state after the current bit is shifted in.
  - `k` is 0 if no such value exists.
- Match: `k == len`.
- On a match with `ovl` = 1:
  - `match` <= 1 and `progress` <= `len`.
  - History is retained, so the next bit may extend a suffix of the match.
- On a match with `ovl` = 0:
  - `match` <= 1 and `progress` <= `len`.
  - `fill` <= 0, so the next bit starts a fresh epoch.
- On a cycle with `in_valid` = 0:
  - `hist`, `fill` and `progress` hold.
  - `match` <= 0.
- `cfg_load`:
  - Latches the configuration.
  - Clears `fill`, `progress` and `match`.
  - Has priority over `in_valid`; a bit presented in the same cycle is dropped.
- `match_count`:
  - Increments on each match and saturates at all-ones.
  - When `clr_count` and a match coincide, the counter becomes 1.
  - `cfg_load` does not clear the counter.
- Reset values:
  - `match` = 0, `progress` = 0, `match_count` = 0.
  - `hist` = 0, `fill` = 0.
  - Configuration registers take the values listed above.

## Timing
- Latency is one cycle. A bit sampled at edge n produces `match` and `progress` that are valid after edge n and held until edge n+1.
- `match` is never high for two consecutive cycles unless valid bits arrive back to back and each one completes a match. This is possible only with `len` = 1 or with overlap of a periodic pattern.
- Asynchronous reset mid-stream:
  - All outputs clear immediately.
  - The first valid bit after the release edge counts as bit 1 of a new epoch.
- Back-to-back `cfg_load` cycles are legal; the last one wins.

## Structure
- Package `seq_det_pkg` holds:
  - `PROG_W(p)` = $clog2(p+1).
  - The reset constants for `len` and `ovl`.
- Sub-module `seq_prefix_match`:
  - Purely combinational.
  - Inputs: `hist'`, `fill'`, `pat` and `len`.
  - Output: `k`, computed by a priority search from PAT_W down to 1.
- The top level holds the registers, the epoch control and the counter.

## Test plan
- Overlap on: `cfg_pattern` = 1001, `len` = 4, stream 1,0,0,1,0,0,1.
  - `progress` = 1,2,3,4,2,3,4.
  - `match` after bits 4 and 7; `match_count` = 2.
- Non-overlap, same stream as above:
  - `match` only after bit 4.
  - `progress` after bits 5–7 = 0,0,1.
  - `match_count` = 1.
- `in_valid` gaps: insert two idle cycles between each bit of 1001.
  - `progress` holds during the gaps.
  - A single `match` pulse occurs one cycle after bit 4 is sampled.
- Saturation with CNT_W = 2: generate 5 matches of pattern 11 (`len` = 2, overlap), stream 1×6.
  - `match_count` = 1,2,3,3,3.
  - `clr_count` concurrent with a match gives `match_count` = 1.
- Config and reset:
  - `cfg_load` with `cfg_len` = 0 and a valid bit in the same cycle: `len` = PAT_W, the bit is dropped, `progress` = 0.
  - Assert `reset_n` low between clock edges mid-stream: all outputs read 0 before the next edge.
